// File: rtl/wta_spike_tally.sv
// -----------------------------------------------------------------------------
// wta_spike_tally
//
// Purpose
//   Decoder for the spike outputs of a winner-take-all LIF network. A window
//   of programmable length is opened by a start pulse. During the window every
//   channel counts its spikes in a saturating counter. After the window the
//   block picks the channel with the highest count and reports:
//     - the winner index (lowest index wins a tie)
//     - the winner count
//     - a tie flag
//     - a no-spike flag
//   A one-cycle valid pulse marks each new result.
//
// Ports
//   clk           in   1          single clock, all state on posedge
//   rst           in   1          asynchronous, active-high reset
//   start         in   1          begin a window; ignored unless idle
//   window_len    in   WIN_W      window length, sampled when start is taken
//   spike_in      in   N_NEURONS  one spike bit per neuron
//   busy          out  1          window counting or resolving
//   result_valid  out  1          one-cycle pulse, result outputs updated
//   winner_idx    out  IDX_W      index of the channel with the highest count
//   winner_count  out  CNT_W      count of that channel
//   tie           out  1          two or more channels share a non-zero maximum
//   no_spike      out  1          every count in the window was zero
//   dbg_state     out  2          current FSM state (IDLE=0, COUNT=1, RESOLVE=2)
//
// Handshake
//   start is a request qualified only by the FSM being idle; there is no
//   ready signal and a start seen while busy is dropped, not queued.
//   result_valid is a single-cycle strobe with no back-pressure; the result
//   outputs hold their value until the next strobe or reset.
//
// Timing (start accepted in cycle t, window length L)
//   L > 0 : samples in t+1 .. t+L, RESOLVE in t+L+1, result_valid in t+L+2
//   L = 0 : RESOLVE in t+1, result_valid in t+2, all counts zero
// -----------------------------------------------------------------------------
module wta_spike_tally #(
    parameter int  N_NEURONS = 4,
    parameter int  CNT_W     = 8,
    parameter int  WIN_W     = 8,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIN_W-1:0]     window_len,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 busy,
    output logic                 result_valid,
    output logic [IDX_W-1:0]     winner_idx,
    output logic [CNT_W-1:0]     winner_count,
    output logic                 tie,
    output logic                 no_spike,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_RESOLVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIN_W-1:0]       r_remaining;
    logic [CNT_W-1:0]       r_cnt [N_NEURONS];

    logic                   r_result_valid;
    logic [IDX_W-1:0]       r_winner_idx;
    logic [CNT_W-1:0]       r_winner_count;
    logic                   r_tie;
    logic                   r_no_spike;

    logic                   w_accept;
    logic                   w_last_sample;
    logic [IDX_W-1:0]       w_max_idx;
    logic [CNT_W-1:0]       w_max_cnt;
    logic                   w_dup_max;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    assign w_accept      = (r_state == ST_IDLE) && start;
    assign w_last_sample = (r_state == ST_COUNT) && (r_remaining == WIN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // A zero-length window has nothing to sample.
                    w_state_nxt = (window_len == '0) ? ST_RESOLVE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_last_sample) begin
                    w_state_nxt = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Window length and per-channel counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (w_accept) begin
            r_remaining <= window_len;
        end else if (r_state == ST_COUNT) begin
            r_remaining <= r_remaining - WIN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_state == ST_COUNT) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                // Saturate instead of wrapping so a flooded channel still wins.
                if (spike_in[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Argmax. Strict '>' keeps the lowest index on equal counts. A second pass
    // looks for any other channel holding the same maximum to flag a tie.
    // -------------------------------------------------------------------------
    always_comb begin
        w_max_idx = '0;
        w_max_cnt = r_cnt[0];
        w_dup_max = 1'b0;
        for (int i = 1; i < N_NEURONS; i++) begin
            if (r_cnt[i] > w_max_cnt) begin
                w_max_cnt = r_cnt[i];
                w_max_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_NEURONS; i++) begin
            if ((r_cnt[i] == w_max_cnt) && (IDX_W'(i) != w_max_idx)) begin
                w_dup_max = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result_valid <= 1'b0;
            r_winner_idx   <= '0;
            r_winner_count <= '0;
            r_tie          <= 1'b0;
            r_no_spike     <= 1'b0;
        end else begin
            r_result_valid <= (r_state == ST_RESOLVE);
            if (r_state == ST_RESOLVE) begin
                r_winner_idx   <= w_max_idx;
                r_winner_count <= w_max_cnt;
                // With max == 0 every channel "ties", but that is reported
                // as no_spike, never as a tie.
                r_tie          <= w_dup_max && (w_max_cnt != '0);
                r_no_spike     <= (w_max_cnt == '0);
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign result_valid = r_result_valid;
    assign winner_idx   = r_winner_idx;
    assign winner_count = r_winner_count;
    assign tie          = r_tie;
    assign no_spike     = r_no_spike;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_wta_spike_tally.sv
// -----------------------------------------------------------------------------
// tb_wta_spike_tally
// Directed and random windows on two instances: the default CNT_W=8 build and
// a CNT_W=4 build used for saturation. Expected results come from a behavioural
// model of the spike pattern and are queued when a window starts. A monitor per
// instance pops the queue on each result_valid pulse. Cycle timing is checked
// inline by the window task.
// -----------------------------------------------------------------------------
module tb_wta_spike_tally;

    // ---------------------------------------------------------------- clock/reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic       start = 1'b0;
    logic [7:0] window_len = 8'd0;
    logic [3:0] spike_in = 4'd0;
    logic       busy, result_valid, tie, no_spike;
    logic [1:0] winner_idx, dbg_state;
    logic [7:0] winner_count;

    logic       start4 = 1'b0;
    logic [7:0] window_len4 = 8'd0;
    logic       busy4, result_valid4, tie4, no_spike4;
    logic [1:0] winner_idx4, dbg_state4;
    logic [3:0] winner_count4;

    wta_spike_tally u_dut (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len),
        .spike_in(spike_in), .busy(busy), .result_valid(result_valid),
        .winner_idx(winner_idx), .winner_count(winner_count), .tie(tie),
        .no_spike(no_spike), .dbg_state(dbg_state)
    );

    wta_spike_tally #(.N_NEURONS(4), .CNT_W(4), .WIN_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .window_len(window_len4),
        .spike_in(spike_in), .busy(busy4), .result_valid(result_valid4),
        .winner_idx(winner_idx4), .winner_count(winner_count4), .tie(tie4),
        .no_spike(no_spike4), .dbg_state(dbg_state4)
    );

    // ---------------------------------------------------------------- scoreboard
    // Result word: {no_spike, tie, winner_idx[1:0], winner_count[7:0]}
    localparam int W = 12;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp4_q[$];
    logic [3:0]   pat [0:255];
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input int len, input int cw);
        int c [4];
        int maxv;
        int best;
        int nmax;
        logic t;
        logic ns;
        maxv = (1 << cw) - 1;
        for (int i = 0; i < 4; i++) c[i] = 0;
        for (int j = 0; j < len; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (pat[j][i] && c[i] < maxv) c[i]++;
            end
        end
        best = 0;
        for (int i = 1; i < 4; i++) if (c[i] > c[best]) best = i;
        nmax = 0;
        for (int i = 0; i < 4; i++) if (c[i] == c[best]) nmax++;
        ns = (c[best] == 0);
        t  = (nmax >= 2) && !ns;
        return {ns, t, best[1:0], c[best][7:0]};
    endfunction

    // Monitors: compare each result pulse with the oldest queued expectation.
    always @(negedge clk) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid8", 32'd1, 32'd0);
            end else begin
                check("result8", {20'd0, no_spike, tie, winner_idx, winner_count},
                      {20'd0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (result_valid4) begin
            if (exp4_q.size() == 0) begin
                check("unexpected_valid4", 32'd1, 32'd0);
            end else begin
                check("result4", {20'd0, no_spike4, tie4, winner_idx4, 4'd0, winner_count4},
                      {20'd0, exp4_q.pop_front()});
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int from, input int to, input logic [3:0] v);
        for (int j = from; j <= to; j++) pat[j] = v;
    endtask

    function automatic logic busy_of(input int which);
        return (which != 0) ? busy4 : busy;
    endfunction

    function automatic logic valid_of(input int which);
        return (which != 0) ? result_valid4 : result_valid;
    endfunction

    // Called in cycle t; returns in cycle t+L+2 (the result_valid cycle).
    // extra_at > 0 raises start again in cycle t+extra_at with a different length.
    task automatic run_window(input int which, input int len, input int extra_at);
        if (which != 0) begin
            exp4_q.push_back(model(len, 4));
            start4      = 1'b1;
            window_len4 = len[7:0];
        end else begin
            exp_q.push_back(model(len, 8));
            start       = 1'b1;
            window_len  = len[7:0];
        end
        tick();
        start  = 1'b0;
        start4 = 1'b0;
        for (int j = 1; j <= len; j++) begin
            spike_in = pat[j-1];
            if (j == extra_at) begin
                start      = 1'b1;
                window_len = 8'd3;
            end
            check("busy_in_count", {31'd0, busy_of(which)}, 32'd1);
            check("no_valid_in_count", {31'd0, valid_of(which)}, 32'd0);
            tick();
            start = 1'b0;
        end
        spike_in = 4'd0;
        check("busy_in_resolve", {31'd0, busy_of(which)}, 32'd1);
        check("no_valid_in_resolve", {31'd0, valid_of(which)}, 32'd0);
        tick();
        check("valid_pulse", {31'd0, valid_of(which)}, 32'd1);
        check("idle_at_valid", {31'd0, busy_of(which)}, 32'd0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_outputs", {20'd0, no_spike, tie, winner_idx, winner_count}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        tick();

        // Dominant channel 2: 6 spikes vs 3 on channel 0.
        fill(0, 5, 4'b0100); fill(6, 8, 4'b0001); fill(9, 9, 4'b0000);
        run_window(0, 10, 0);
        tick();

        // Channels 1 and 3 tie at 4; lowest index reported.
        fill(0, 3, 4'b1010); fill(4, 7, 4'b0000);
        run_window(0, 8, 0);
        tick();

        // Start at t+3 is dropped (and its length ignored); a start in the
        // result cycle is taken, here a zero-length window.
        fill(0, 4, 4'b1000); fill(5, 9, 4'b0000);
        run_window(0, 10, 3);
        run_window(0, 0, 0);
        tick();

        // Silent five-cycle window.
        fill(0, 4, 4'b0000);
        run_window(0, 5, 0);
        tick();

        // Give the outputs a non-zero result, then reset mid-window.
        fill(0, 2, 4'b0010);
        run_window(0, 3, 0);
        tick();
        fill(0, 19, 4'b0010);
        start = 1'b1; window_len = 8'd20;
        tick();
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            spike_in = pat[j];
            tick();
        end
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, result_valid}, 32'd0);
        check("midrst_outputs", {20'd0, no_spike, tie, winner_idx, winner_count}, 32'd0);
        check("midrst_state", {30'd0, dbg_state}, 32'd0);
        tick();
        rst = 1'b0;
        spike_in = 4'd0;
        for (int j = 0; j < 25; j++) begin
            check("no_valid_after_abort", {31'd0, result_valid}, 32'd0);
            tick();
        end

        // Clean window after the abort.
        fill(0, 1, 4'b0001); fill(2, 3, 4'b0000);
        run_window(0, 4, 0);
        tick();

        // Random windows with arbitrary multi-bit spike patterns.
        for (int k = 0; k < 4; k++) begin
            int len;
            len = $urandom_range(1, 30);
            for (int j = 0; j < len; j++) pat[j] = 4'($urandom_range(0, 15));
            run_window(0, len, 0);
            tick();
        end

        // Saturation on the 4-bit instance.
        fill(0, 254, 4'b0001);
        run_window(1, 255, 0);
        tick();

        // Two channels both saturated count as a tie.
        fill(0, 39, 4'b0011);
        run_window(1, 40, 0);
        tick();

        tick();
        check("queue8_drained", exp_q.size(), 32'd0);
        check("queue4_drained", exp4_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
